bcd_score_accumulator: RTL and testbench
========================================

// Module: bcd_score_accumulator
// PURPOSE
//  Parametrised BCD score keeper: replaces the fixed 3-digit +1 scoreboard.
//  Adds 0-9 points per hit, subtracts 0-9 points per miss, and optionally saturates.
//  Tracks a session high score. Feeds the 7-seg display driver and the game FSM, which
//  pulses clear on LOAD and drives add/sub during START.
//  Fully synchronous datapath; ripple is computed combinationally, never clocked through digits.
// PARAMETERS
//  NUM_DIGITS  3  BCD digits held (1..6); max score = 10^NUM_DIGITS-1
//  SATURATE    1  1: clamp at max score; 0: wrap modulo 10^NUM_DIGITS
// PORTS
//  clk         in   1             system clock, all state on rising edge
//  rst         in   1             asynchronous reset, active high; clears score and high score
//  clear       in   1             sync, active high: score <- 0 (high score kept)
//  clear_high  in   1             sync, active high: high score <- 0
//  add_valid   in   1             add add_amt this cycle
//  add_amt     in   4             points to add, binary 0..9 (values >9 treated as 9)
//  sub_valid   in   1             subtract sub_amt this cycle
//  sub_amt     in   4             points to subtract, binary 0..9 (values >9 treated as 9)
//  score_bcd   out  4*NUM_DIGITS  current score, digit 0 (ones) in [3:0]
//  high_bcd    out  4*NUM_DIGITS  session high score, same packing
//  new_high    out  1             1-cycle pulse: high score raised this cycle
//  overflow    out  1             1-cycle pulse: add exceeded max (clamped or wrapped)
//  underflow   out  1             1-cycle pulse: subtract went below 0 (clamped to 0)
// BEHAVIOUR
//  - Reset (rst=1, async): score_bcd=0, high_bcd=0, new_high=0, overflow=0, underflow=0.
//  - All outputs are registered. An update is visible on the edge after the inputs are sampled.
//  - Priority per edge: clear > add/sub. With clear=1, add/sub are ignored and all flags are 0.
//  - clear_high is independent of clear. With clear_high=1, high <- 0 this edge
//    and no new_high pulse is produced that edge.
//  - Net delta per cycle: (add_valid?min(add_amt,9):0) - (sub_valid?min(sub_amt,9):0), range -9..+9.
//    add and sub in the same cycle combine into one update, e.g. +5 and -3 gives +2.
//    Zero net: score holds and no flags are raised.
//  - Positive delta: per-digit BCD add with carry, digit 0 upward.
//    Carry out of the top digit means overflow=1.
//    SATURATE=1: score <- all 9s.
//    SATURATE=0: score <- low NUM_DIGITS digits of the sum (wrap).
//  - Negative delta: per-digit BCD subtract with borrow.
//    Borrow out of the top digit means underflow=1 and score <- 0, in both modes.
//  - High score: when clear_high=0 and next score > high_bcd (BCD magnitude compare),
//    high <- next score on the same edge as the score, and new_high=1.
//    A wrap to a small value never lowers high_bcd.
//  - Flags are high for exactly one cycle per causing edge and deassert on the next edge
//    unless retriggered.
//  - rst asserted mid-stream overrides everything immediately. The first update after
//    rst deasserts starts from 0.
//  - Digit registers never hold values >9.
// TESTING
//  1 rst pulse, then 12 cycles of add 1 -> score 012, high 012, new_high each cycle, no flags
//  2 score 095, add 7 + sub 2 same cycle -> score 100, new_high=1
//  3 score 004, sub 9 -> score 000, underflow=1 for one cycle; high unchanged
//  4 SATURATE=1, score 995, add 9 -> 999, overflow=1; SATURATE=0 same stimulus -> 004, overflow=1, high stays 995
//  5 score 050 high 080, clear + add 5 -> score 000, high 080, no flags; then clear_high -> high 000
//  6 add_amt=15 treated as 9; rst asserted between edges -> all outputs 0 immediately, flags low

Source files
------------

// File: rtl/bcd_score_accumulator.sv
// Parametrised BCD score keeper: signed per-cycle delta of -9..+9 applied with digit ripple,
// optional saturation at all-9s, and a session high score with registered event pulses.
module bcd_score_accumulator #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    clear_high_i,
    input  logic                    add_valid_i,
    input  logic [3:0]              add_amt_i,
    input  logic                    sub_valid_i,
    input  logic [3:0]              sub_amt_i,
    output logic [4*NUM_DIGITS-1:0] score_bcd_o,
    output logic [4*NUM_DIGITS-1:0] high_bcd_o,
    output logic                    new_high_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int unsigned W = 4 * NUM_DIGITS;
    localparam logic [W-1:0] AllNines = {NUM_DIGITS{4'd9}};

    logic [W-1:0] score_q, score_d;
    logic [W-1:0] high_q, high_d;
    logic         new_high_q, new_high_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;

    logic [3:0]   add_eff, sub_eff, mag;
    logic         is_up, is_down;
    logic [W-1:0] sum_bcd, diff_bcd;
    logic         carry_out, borrow_out;

    always_comb begin
        add_eff = add_valid_i ? ((add_amt_i > 4'd9) ? 4'd9 : add_amt_i) : 4'd0;
        sub_eff = sub_valid_i ? ((sub_amt_i > 4'd9) ? 4'd9 : sub_amt_i) : 4'd0;
        is_up   = add_eff > sub_eff;
        is_down = sub_eff > add_eff;
        mag     = is_up ? (add_eff - sub_eff) : (sub_eff - add_eff);
    end

    // Ripple add: digit 0 absorbs the whole magnitude, higher digits only see a 0/1 carry.
    always_comb begin
        logic [4:0] acc;
        logic [4:0] c;
        sum_bcd = '0;
        c       = {1'b0, mag};
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            acc = {1'b0, score_q[4*i +: 4]} + c;
            if (acc > 5'd9) begin
                sum_bcd[4*i +: 4] = 4'(acc - 5'd10);
                c                 = 5'd1;
            end else begin
                sum_bcd[4*i +: 4] = acc[3:0];
                c                 = 5'd0;
            end
        end
        carry_out = (c != 5'd0);
    end

    always_comb begin
        logic [4:0] d;
        logic [4:0] b;
        diff_bcd = '0;
        b        = {1'b0, mag};
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            d = {1'b0, score_q[4*i +: 4]};
            if (d < b) begin
                diff_bcd[4*i +: 4] = 4'(d + 5'd10 - b);
                b                  = 5'd1;
            end else begin
                diff_bcd[4*i +: 4] = 4'(d - b);
                b                  = 5'd0;
            end
        end
        borrow_out = (b != 5'd0);
    end

    always_comb begin
        score_d     = score_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (clear_i) begin
            score_d = '0;
        end else if (is_up) begin
            if (carry_out) begin
                overflow_d = 1'b1;
                score_d    = SATURATE ? AllNines : sum_bcd;
            end else begin
                score_d = sum_bcd;
            end
        end else if (is_down) begin
            if (borrow_out) begin
                underflow_d = 1'b1;
                score_d     = '0;
            end else begin
                score_d = diff_bcd;
            end
        end

        // Packed BCD with legal digits orders the same as plain binary.
        high_d     = high_q;
        new_high_d = 1'b0;
        if (clear_high_i) begin
            high_d = '0;
        end else if (score_d > high_q) begin
            high_d     = score_d;
            new_high_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            score_q     <= '0;
            high_q      <= '0;
            new_high_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            score_q     <= score_d;
            high_q      <= high_d;
            new_high_q  <= new_high_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign score_bcd_o = score_q;
    assign high_bcd_o  = high_q;
    assign new_high_o  = new_high_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_bcd_score_accumulator.sv
// Bench for bcd_score_accumulator: saturating and wrapping instances driven in lockstep and
// checked against an integer-arithmetic score model.
module tb_bcd_score_accumulator;

    localparam int MAXV = 999;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clear, clear_high, add_valid, sub_valid;
    logic [3:0] add_amt, sub_amt;

    logic [11:0] score_s, high_s, score_w, high_w;
    logic        nh_s, ov_s, uf_s, nh_w, ov_w, uf_w;

    bcd_score_accumulator #(.NUM_DIGITS(3), .SATURATE(1'b1)) u_sat (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .clear_high_i(clear_high),
        .add_valid_i(add_valid), .add_amt_i(add_amt),
        .sub_valid_i(sub_valid), .sub_amt_i(sub_amt),
        .score_bcd_o(score_s), .high_bcd_o(high_s),
        .new_high_o(nh_s), .overflow_o(ov_s), .underflow_o(uf_s)
    );

    bcd_score_accumulator #(.NUM_DIGITS(3), .SATURATE(1'b0)) u_wrap (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .clear_high_i(clear_high),
        .add_valid_i(add_valid), .add_amt_i(add_amt),
        .sub_valid_i(sub_valid), .sub_amt_i(sub_amt),
        .score_bcd_o(score_w), .high_bcd_o(high_w),
        .new_high_o(nh_w), .overflow_o(ov_w), .underflow_o(uf_w)
    );

    // Model state: index 0 saturating, index 1 wrapping.
    int m_score[2];
    int m_high[2];
    bit m_nh[2], m_ov[2], m_uf[2];
    int checks   = 0;
    int failures = 0;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_score[k] = 0; m_high[k] = 0;
            m_nh[k] = 0; m_ov[k] = 0; m_uf[k] = 0;
        end
    endtask

    task automatic model_update();
        int a, s, d, t;
        a = add_valid ? ((add_amt > 4'd9) ? 9 : int'(add_amt)) : 0;
        s = sub_valid ? ((sub_amt > 4'd9) ? 9 : int'(sub_amt)) : 0;
        d = a - s;
        for (int k = 0; k < 2; k++) begin
            m_nh[k] = 0; m_ov[k] = 0; m_uf[k] = 0;
            if (clear) begin
                m_score[k] = 0;
            end else begin
                t = m_score[k] + d;
                if (t > MAXV) begin
                    m_ov[k]    = 1;
                    m_score[k] = (k == 0) ? MAXV : t - (MAXV + 1);
                end else if (t < 0) begin
                    m_uf[k]    = 1;
                    m_score[k] = 0;
                end else begin
                    m_score[k] = t;
                end
            end
            if (clear_high) begin
                m_high[k] = 0;
            end else if (m_score[k] > m_high[k]) begin
                m_high[k] = m_score[k];
                m_nh[k]   = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " sat.score"}, score_s, to_bcd(m_score[0]));
        chk({tag, " sat.high"}, high_s, to_bcd(m_high[0]));
        chk({tag, " sat.new_high"}, {11'b0, nh_s}, {11'b0, m_nh[0]});
        chk({tag, " sat.overflow"}, {11'b0, ov_s}, {11'b0, m_ov[0]});
        chk({tag, " sat.underflow"}, {11'b0, uf_s}, {11'b0, m_uf[0]});
        chk({tag, " wrap.score"}, score_w, to_bcd(m_score[1]));
        chk({tag, " wrap.high"}, high_w, to_bcd(m_high[1]));
        chk({tag, " wrap.new_high"}, {11'b0, nh_w}, {11'b0, m_nh[1]});
        chk({tag, " wrap.overflow"}, {11'b0, ov_w}, {11'b0, m_ov[1]});
        chk({tag, " wrap.underflow"}, {11'b0, uf_w}, {11'b0, m_uf[1]});
    endtask

    // Apply one cycle of inputs, then check one time unit after the edge.
    task automatic step(input bit c, input bit ch, input bit av, input logic [3:0] aa,
                        input bit sv, input logic [3:0] sa, input string tag);
        clear = c; clear_high = ch;
        add_valid = av; add_amt = aa;
        sub_valid = sv; sub_amt = sa;
        @(posedge clk);
        #1;
        model_update();
        check_all(tag);
    endtask

    task automatic add_up(input int n, input string tag);
        int r;
        r = n;
        while (r > 0) begin
            step(0, 0, 1, 4'((r > 9) ? 9 : r), 0, 4'd0, tag);
            r = r - ((r > 9) ? 9 : r);
        end
    endtask

    initial begin
        rst = 1'b1; clear = 0; clear_high = 0;
        add_valid = 0; add_amt = '0; sub_valid = 0; sub_amt = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Twelve +1 hits
        repeat (12) step(0, 0, 1, 4'd1, 0, 4'd0, "t1 add1");
        chk("t1 score==012", score_s, 12'h012);
        chk("t1 high==012", high_s, 12'h012);

        // 095, then +7 and -2 together
        step(1, 0, 0, 4'd0, 0, 4'd0, "t2 clear");
        add_up(95, "t2 fill");
        step(0, 0, 1, 4'd7, 1, 4'd2, "t2 combo");
        chk("t2 score==100", score_s, 12'h100);
        chk("t2 new_high", {11'b0, nh_s}, 12'h001);

        // 004 minus 9 clamps to zero
        step(1, 0, 0, 4'd0, 0, 4'd0, "t3 clear");
        add_up(4, "t3 fill");
        step(0, 0, 0, 4'd0, 1, 4'd9, "t3 sub9");
        chk("t3 score==000", score_s, 12'h000);
        chk("t3 underflow", {11'b0, uf_s}, 12'h001);
        chk("t3 high==100", high_s, 12'h100);
        step(0, 0, 0, 4'd0, 0, 4'd0, "t3 idle");

        // 995 plus 9: saturate vs wrap
        step(1, 0, 0, 4'd0, 0, 4'd0, "t4 clear");
        add_up(995, "t4 fill");
        step(0, 0, 1, 4'd9, 0, 4'd0, "t4 add9");
        chk("t4 sat score==999", score_s, 12'h999);
        chk("t4 wrap score==004", score_w, 12'h004);
        chk("t4 wrap high==995", high_w, 12'h995);
        chk("t4 wrap overflow", {11'b0, ov_w}, 12'h001);
        step(0, 0, 0, 4'd0, 0, 4'd0, "t4 idle");

        // clear beats add; clear_high independent
        step(1, 1, 0, 4'd0, 0, 4'd0, "t5 clr both");
        add_up(80, "t5 fill80");
        step(1, 0, 0, 4'd0, 0, 4'd0, "t5 clear");
        add_up(50, "t5 fill50");
        step(1, 0, 1, 4'd5, 0, 4'd0, "t5 clear+add");
        chk("t5 score==000", score_s, 12'h000);
        chk("t5 high==080", high_s, 12'h080);
        step(0, 1, 0, 4'd0, 0, 4'd0, "t5 clear_high");
        chk("t5 high==000", high_w, 12'h000);

        // Clamp of amounts above 9, then async reset between edges
        step(0, 0, 1, 4'd15, 0, 4'd0, "t6 add15");
        chk("t6 score==009", score_s, 12'h009);
        step(1, 0, 0, 4'd0, 0, 4'd0, "t6 clear");
        step(0, 0, 0, 4'd0, 1, 4'd15, "t6 sub15");
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("t6 async rst");
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 4'd3, 0, 4'd0, "t6 post rst");

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 149) == 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
